spr_bist_ctrl: RTL
==================

Name: spr_bist_ctrl

Overview:
- Built-in self-test initiator for the single-port RAM (`SPR_design`). It drives the RAM's data, address and WEN inputs and checks Q.
- On `start` it runs a March C- style sequence over every address and compares each read against the expected value.
- It reports pass/fail, the first failing address and a failure count.
- It sits between system control logic and one RAM instance and owns the RAM port while `busy`=1.

Parameters:
- AW, 8, address width
- DW, 16, data width
- DEPTH, 256, number of words tested (≤ 2**AW)
- PATTERN, 16'hA5A5, background pattern; its complement is ~PATTERN

Ports:
- CLK  input  1  clock, rising edge
- RSTN  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; starts a test when idle
- busy  output  1  test in progress
- done  output  1  one-cycle pulse when the test ends
- pass  output  1  valid after `done`: 1 = no mismatches
- fail_addr  output  AW  address of the first mismatch
- fail_count  output  8  number of mismatches, saturating at 255
- mem_data  output  DW  RAM write data
- mem_address  output  AW  RAM address
- mem_wen  output  1  RAM write enable, 1 = write
- mem_q  input  DW  RAM read data

Behaviour:
- RAM contract (decided):
  - Write occurs on the rising edge when mem_wen=1.
  - Read with mem_wen=0: Q is registered and valid in the cycle after the address edge.
- Reset values (RSTN low, asynchronous): busy=0, done=0, pass=0, fail_addr=0, fail_count=0, mem_data=0, mem_address=0, mem_wen=0, state=IDLE.
- FSM states: IDLE, W0_UP, R0W1_UP, R1W0_DN, R0_DN, FLUSH, FIN.
- IDLE:
  - `start` → clear pass, fail_count, fail_addr → W0_UP, address 0, busy=1.
  - `start` while busy is ignored.
- W0_UP: write PATTERN to address 0..DEPTH-1, one per cycle.
- R0W1_UP, ascending addresses, 2 cycles per address:
  - Cycle 1: read.
  - Cycle 2: write ~PATTERN, and compare mem_q against PATTERN.
- R1W0_DN, descending DEPTH-1..0: same two-cycle scheme; expect ~PATTERN, write PATTERN.
- R0_DN, descending:
  - Reads pipelined one per cycle.
  - Compare of address a occurs in the cycle after its read, against PATTERN.
  - FLUSH performs the last compare (address 0).
- FIN: `done`=1 for one cycle, pass=(fail_count==0), busy=0 → IDLE.
- Compare pipeline: exp_valid/exp_val/exp_addr are registered with each read and consumed the next cycle.
- On mismatch:
  - fail_count increments, saturating at 255.
  - fail_addr is loaded only on the first mismatch.
- Total latency from the `start` edge to `done` = 6·DEPTH+2 cycles.
- Address wrap: the counter never wraps.
  - Ascending elements end at DEPTH-1.
  - Descending elements end at 0; the transition is taken on the terminal address, with no underflow.
- Outside a write cycle mem_wen=0. In IDLE, mem_address and mem_data hold 0.
- Reset mid-test aborts immediately to reset values. RAM contents are undefined afterwards; no `done` is issued.
- pass, fail_addr and fail_count hold until the next `start`.

Optional Feature:
- Macro: SPR_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the test.
  - Next state is FIN regardless of the current element; no further RAM writes are issued.
  - fail_count=1, pass=0.
- Undefined: the test always runs to completion and counts every mismatch.

Decomposition:
- Shared package `spr_pkg`:
  - AW/DW/DEPTH defaults.
  - FSM state enumeration (3-bit encoding).
  - PATTERN default.
- One natural sub-module, `spr_bist_cmp`:
  - Registered expected-value pipeline, comparator, saturating fail counter and first-fail latch.
  - Interface: exp_valid/exp_val/exp_addr in; mismatch, fail_addr, fail_count out.
- The FSM and address counter stay in the top level.

Test Plan (AW=4, DEPTH=16, DW=16, behavioural registered-read RAM model):
- Fault-free RAM, pulse `start` → busy high for 98 cycles; `done` pulse; pass=1, fail_count=0. Final RAM contents all 16'hA5A5.
- Stuck-at-0 on bit 0 at address 5 → mismatch in R0W1_UP (expect A5A5, got A5A4) and in R0_DN → pass=0, fail_addr=5, fail_count=2.
  - With SPR_BIST_STOP_ON_FAIL_EN: `done` after the first failure, fail_count=1, and addresses 6..15 never written ~PATTERN.
- Address alias (writes to address 9 also land at address 1) → pass=0, fail_addr=1.
- Assert RSTN low at cycle 40 of a test → all outputs zero asynchronously, no `done`. New `start` after release → full 98-cycle run, pass=1.
- `start` pulsed repeatedly while busy → ignored; exactly one `done`. Back-to-back `start` the cycle after `done` → second test runs and clears the previous results.
- Protocol monitor: mem_wen=1 only in W0_UP and the write cycles of R0W1_UP/R1W0_DN. Address sequence 0..15, 0..15 (×2 cycles), 15..0 (×2 cycles), 15..0.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared defaults and FSM state encoding for the single-port RAM BIST controller.
package spr_pkg;

  localparam int unsigned SPR_AW      = 8;
  localparam int unsigned SPR_DW      = 16;
  localparam int unsigned SPR_DEPTH   = 256;
  localparam logic [15:0] SPR_PATTERN = 16'hA5A5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W0_UP   = 3'd1,
    R0W1_UP = 3'd2,
    R1W0_DN = 3'd3,
    R0_DN   = 3'd4,
    FLUSH   = 3'd5,
    FIN     = 3'd6
  } bist_state_e;

endpackage

// File: rtl/spr_bist_ctrl_if.sv
// RAM-side port bundle: the BIST drives data/address/WEN and samples Q.
interface spr_bist_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_address;
  logic          mem_wen;
  logic [DW-1:0] mem_q;

  modport master (output mem_data, output mem_address, output mem_wen, input mem_q);
  modport slave  (input mem_data, input mem_address, input mem_wen, output mem_q);
endinterface

// File: rtl/spr_bist_cmp.sv
// Expected-value pipeline, read-data comparator, saturating fail counter and first-fail latch.
module spr_bist_cmp
  import spr_pkg::*;
#(
  parameter int unsigned AW = SPR_AW,
  parameter int unsigned DW = SPR_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          exp_valid_i,
  input  logic [DW-1:0] exp_val_i,
  input  logic [AW-1:0] exp_addr_i,
  input  logic [DW-1:0] q_i,
  output logic          mismatch_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [7:0]    fail_count_o
);

  logic          exp_valid_q;
  logic [DW-1:0] exp_val_q;
  logic [AW-1:0] exp_addr_q;
  logic [AW-1:0] fail_addr_q;
  logic [7:0]    fail_count_q;

  // Q is registered in the RAM, so the expectation is delayed one cycle to line up with it.
  assign mismatch_o   = exp_valid_q && (q_i != exp_val_q);
  assign fail_addr_o  = fail_addr_q;
  assign fail_count_o = fail_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_valid_q  <= 1'b0;
      exp_val_q    <= '0;
      exp_addr_q   <= '0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      exp_valid_q <= exp_valid_i;
      exp_val_q   <= exp_val_i;
      exp_addr_q  <= exp_addr_i;
      if (clr_i) begin
        fail_addr_q  <= '0;
        fail_count_q <= '0;
      end else if (mismatch_o) begin
        if (fail_count_q == '0) fail_addr_q <= exp_addr_q;
        if (fail_count_q != '1) fail_count_q <= fail_count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spr_bist_ctrl.sv
// March C- BIST initiator for one single-port RAM: FSM and address counter, compare in spr_bist_cmp.
// Build option SPR_BIST_STOP_ON_FAIL_EN: end the test at the first mismatch.
module spr_bist_ctrl
  import spr_pkg::*;
#(
  parameter int unsigned   AW      = SPR_AW,
  parameter int unsigned   DW      = SPR_DW,
  parameter int unsigned   DEPTH   = SPR_DEPTH,
  parameter logic [DW-1:0] PATTERN = DW'(SPR_PATTERN)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW-1:0]   fail_addr,
  output logic [7:0]      fail_count,
  spr_bist_ctrl_if.master mem
);

`ifdef SPR_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  bist_state_e   state_q;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic          busy_q, done_q, pass_q, wen_q;
  logic [DW-1:0] data_q;
  logic          rd_cyc, exp_load, mismatch, stop, clr;
  logic [DW-1:0] exp_val;

  always_comb begin
    rd_cyc   = ((state_q == R0W1_UP || state_q == R1W0_DN) && !wr_q) || (state_q == R0_DN);
    exp_val  = (state_q == R1W0_DN) ? ~PATTERN : PATTERN;
    stop     = STOP_EN && mismatch;
    // A read issued in the stopping cycle must not arm a compare inside FIN.
    exp_load = rd_cyc && !stop;
    clr      = (state_q == IDLE) && start;
  end

  spr_bist_cmp #(.AW(AW), .DW(DW)) u_cmp (
    .clk_i       (CLK),
    .rst_ni      (RSTN),
    .clr_i       (clr),
    .exp_valid_i (exp_load),
    .exp_val_i   (exp_val),
    .exp_addr_i  (addr_q),
    .q_i         (mem.mem_q),
    .mismatch_o  (mismatch),
    .fail_addr_o (fail_addr),
    .fail_count_o(fail_count)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      wen_q  <= 1'b0;
      data_q <= '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= W0_UP;
          addr_q  <= '0;
          busy_q  <= 1'b1;
          pass_q  <= 1'b0;
          wen_q   <= 1'b1;
          data_q  <= PATTERN;
        end
        W0_UP: if (addr_q == LAST) begin
          state_q <= R0W1_UP;
          addr_q  <= '0;
          wr_q    <= 1'b0;
        end else begin
          addr_q <= addr_q + 1'b1;
          wen_q  <= 1'b1;
          data_q <= PATTERN;
        end
        R0W1_UP: if (!wr_q) begin
          wr_q   <= 1'b1;
          wen_q  <= 1'b1;
          data_q <= ~PATTERN;
        end else begin
          wr_q <= 1'b0;
          if (addr_q == LAST) begin
            state_q <= R1W0_DN;
            addr_q  <= LAST;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        R1W0_DN: if (!wr_q) begin
          wr_q   <= 1'b1;
          wen_q  <= 1'b1;
          data_q <= PATTERN;
        end else begin
          wr_q <= 1'b0;
          if (addr_q == '0) begin
            state_q <= R0_DN;
            addr_q  <= LAST;
          end else begin
            addr_q <= addr_q - 1'b1;
          end
        end
        R0_DN: if (addr_q == '0) state_q <= FLUSH;
               else addr_q <= addr_q - 1'b1;
        FLUSH: state_q <= FIN;
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (fail_count == '0);
        end
        default: state_q <= IDLE;
      endcase
      if (stop) begin
        state_q <= FIN;
        addr_q  <= '0;
        wr_q    <= 1'b0;
        wen_q   <= 1'b0;
        data_q  <= '0;
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mem.mem_data    = data_q;
  assign mem.mem_address = addr_q;
  assign mem.mem_wen     = wen_q;

endmodule
